// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle shift unit for the ALU shift path (SLL / SRL / SRA). One operand
// and a shift amount are accepted through a valid/ready handshake. The fixed
// power-of-two stages (16, 8, 4, 2, 1) are then applied one per clock. Work
// starts at the highest set bit of the shift amount and stops after the lowest
// set bit. Only one operation is in flight at a time.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both high. Valid never waits on ready. Once out_valid
// rises, out_valid and out_data hold until the transfer happens or abort
// flushes the result. abort wins over every handshake in the cycle it is high.
//
// Ports
//   clock      in   sole clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   request present
//   in_ready   out  high exactly when idle
//   in_data    in   operand
//   in_shamt   in   shift amount 0..31
//   in_op      in   00 SLL, 01 SRL, 10 SRA, 11 reserved (runs as SLL)
//   abort      in   synchronous flush of the in-flight operation
//   out_valid  out  result available (DONE state)
//   out_ready  in   consumer takes the result
//   out_data   out  accumulator / result
//   busy       out  SHIFT or DONE
//   dbg_state  out  raw FSM state, for debug and checkers
// ---------------------------------------------------------------------------
module shift_sequencer #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    state_t             r_state;
    logic [WIDTH-1:0]   r_acc;
    logic [SHAMT_W-1:0] r_shamt;
    logic [1:0]         r_op;
    logic [2:0]         r_k;

    logic [2:0]         w_top_bit;
    logic [SHAMT_W-1:0] w_amt;
    logic [SHAMT_W-1:0] w_low_mask;
    logic               w_last;
    logic               w_stage_en;
    logic [WIDTH-1:0]   w_shifted;

    // Index of the highest set bit of the incoming shift amount.
    // An amount of zero never reaches SHIFT, so its result is unused.
    always_comb begin
        w_top_bit = 3'd0;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (in_shamt[i]) begin
                w_top_bit = 3'(i);
            end
        end
    end

    // Stage k shifts by 2^k. The mask covers all lower stages; when none of
    // them are set this is the last stage. k == 0 gives an empty mask.
    assign w_amt      = SHAMT_W'(1) << r_k;
    assign w_low_mask = w_amt - SHAMT_W'(1);
    assign w_last     = ((r_shamt & w_low_mask) == '0);
    assign w_stage_en = r_shamt[r_k];

    always_comb begin
        w_shifted = r_acc << w_amt;
        case (r_op)
            OP_SRL:  w_shifted = r_acc >> w_amt;
            OP_SRA:  w_shifted = WIDTH'($signed(r_acc) >>> w_amt);
            default: w_shifted = r_acc << w_amt;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_shamt <= '0;
            r_op    <= '0;
            r_k     <= '0;
        end else if (abort) begin
            // Flush: drop any work or pending result. The accumulator is kept.
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_acc   <= in_data;
                        r_shamt <= in_shamt;
                        r_op    <= in_op;
                        if (in_shamt == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_k     <= w_top_bit;
                            r_state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (w_stage_en) begin
                        r_acc <= w_shifted;
                    end
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_k <= r_k - 3'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign out_data  = r_acc;
    assign dbg_state = r_state;

endmodule
